// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - command sequencer driving a push/pop stack (PUSHI/POP/ALU/NOT/DUP)
module stack_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_imm,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       err,
    output logic       busy,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_din,
    input  logic [7:0] stk_dout,
    input  logic [7:0] stk_tos
);

    localparam logic [2:0] OP_PUSHI = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_NOT   = 3'b110;
    localparam logic [2:0] OP_DUP   = 3'b111;

    typedef enum logic [2:0] {IDLE, POP_A, POP_B, PUSH_R, DONE, ERR} state_t;

    state_t     state;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] b_cur;
    logic       depth_ok;

    function automatic logic [7:0] alu(input logic [2:0] f, input logic [7:0] x_a,
                                       input logic [7:0] x_b);
        case (f)
            OP_ADD:  alu = x_b + x_a;
            OP_SUB:  alu = x_b - x_a;
            OP_AND:  alu = x_b & x_a;
            OP_OR:   alu = x_b | x_a;
            default: alu = x_a;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE) && rst;

    // b is the post-pop top, visible on stk_dout while in POP_B
    assign b_cur = (state == POP_B) ? stk_dout : b;

    always_comb begin
        depth_ok = 1'b0;
        case (cmd_op)
            OP_PUSHI:       depth_ok = (stk_tos != 8'd255);
            OP_POP, OP_NOT: depth_ok = (stk_tos >= 8'd1);
            OP_DUP:         depth_ok = (stk_tos >= 8'd1) && (stk_tos <= 8'd254);
            default:        depth_ok = (stk_tos >= 8'd2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= 3'd0;
            a         <= 8'd0;
            b         <= 8'd0;
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_din   <= 8'd0;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_din   <= 8'd0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op   <= cmd_op;
                        busy <= 1'b1;
                        if (!depth_ok) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (cmd_op == OP_PUSHI) begin
                            state    <= PUSH_R;
                            stk_push <= 1'b1;
                            stk_din  <= cmd_imm;
                        end else if (cmd_op == OP_DUP) begin
                            state    <= PUSH_R;
                            stk_push <= 1'b1;
                            stk_din  <= stk_dout;
                        end else begin
                            state   <= POP_A;
                            stk_pop <= 1'b1;
                        end
                    end
                end
                POP_A: begin
                    a <= stk_dout;
                    if (op == OP_POP) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= stk_dout;
                    end else if (op == OP_NOT) begin
                        state    <= PUSH_R;
                        stk_push <= 1'b1;
                        stk_din  <= ~stk_dout;
                    end else begin
                        state   <= POP_B;
                        stk_pop <= 1'b1;
                    end
                end
                POP_B: begin
                    b        <= b_cur;
                    state    <= PUSH_R;
                    stk_push <= 1'b1;
                    stk_din  <= alu(op, a, b_cur);
                end
                PUSH_R: begin
                    // stk_din carries the result for the whole PUSH_R cycle
                    state     <= DONE;
                    res_valid <= 1'b1;
                    res_data  <= stk_din;
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - scoreboard bench for stack_op_sequencer with a behavioural stack
module tb_stack_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_imm;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err;
    logic       busy;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic [7:0] stk_tos;

    stack_op_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_imm(cmd_imm), .res_valid(res_valid), .res_data(res_data),
        .err(err), .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .stk_dout(stk_dout), .stk_tos(stk_tos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    logic [7:0] mem [256];
    logic [7:0] tos = 8'd0;
    logic       clr_req = 1'b0;
    logic       pre_req = 1'b0;

    assign stk_tos  = tos;
    assign stk_dout = (tos == 8'd0) ? 8'd0 : mem[tos - 8'd1];

    always @(posedge clk) begin
        if (clr_req) tos <= 8'd0;
        else if (pre_req) begin
            for (int i = 0; i < 255; i++) mem[i] <= 8'(i);
            tos <= 8'd255;
        end else if (stk_push) begin
            mem[tos] <= stk_din;
            tos      <= tos + 8'd1;
        end else if (stk_pop) tos <= tos - 8'd1;
    end

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst && (res_valid || err)) begin
            if (sb.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("err_flag", int'(err), int'(mon_e.is_err));
                chk("res_valid", int'(res_valid), int'(!mon_e.is_err));
                if (!mon_e.is_err) chk("res_data", int'(res_data), int'(mon_e.data));
                chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
        if (stk_push || stk_pop) chk("push_pop_exclusive", int'(stk_push && stk_pop), 0);
        if (!stk_push && stk_din != 8'd0) chk("din_zero_when_idle", int'(stk_din), 0);
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] imm, input logic exp_err,
                         input logic [7:0] exp_data, input int lat, input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        e.is_err = exp_err;
        e.data   = exp_data;
        e.lat    = lat;
        e.acc    = cyc;
        if (track) sb.push_back(e);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_imm   = ~imm;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", int'(sb.size() == 0 && cmd_ready), 1);
    endtask

    task automatic stack_ctl(input bit clr);
        @(negedge clk);
        if (clr) clr_req = 1'b1; else pre_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        pre_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_imm   = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_strobes", int'({stk_push, stk_pop, res_valid, err}), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", int'(cmd_ready), 1);

        // 5 - 3 = 2
        issue(3'b000, 8'd5, 1'b0, 8'd5, 2, 1);
        issue(3'b000, 8'd3, 1'b0, 8'd3, 2, 1);
        issue(3'b011, 8'd0, 1'b0, 8'd2, 4, 1);
        drain();
        chk("sub_tos", int'(tos), 1);
        repeat (3) @(negedge clk);
        chk("res_data_hold", int'(res_data), 2);

        // 200 + 100 wraps to 44
        stack_ctl(1);
        issue(3'b000, 8'd200, 1'b0, 8'd200, 2, 1);
        issue(3'b000, 8'd100, 1'b0, 8'd100, 2, 1);
        issue(3'b010, 8'd0, 1'b0, 8'd44, 4, 1);
        drain();
        chk("add_tos", int'(tos), 1);
        chk("add_top", int'(stk_dout), 44);
        issue(3'b001, 8'd0, 1'b0, 8'd44, 2, 1);
        drain();
        chk("pop_tos", int'(tos), 0);

        // binary op on an empty stack
        issue(3'b010, 8'd0, 1'b1, 8'd0, 1, 1);
        @(negedge clk);
        chk("err_cycle_not_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("err_ready_back", int'(cmd_ready), 1);
        chk("err_tos", int'(tos), 0);
        issue(3'b001, 8'd0, 1'b1, 8'd0, 1, 1);
        issue(3'b111, 8'd0, 1'b1, 8'd0, 1, 1);
        drain();

        // full stack
        stack_ctl(0);
        issue(3'b000, 8'd7, 1'b1, 8'd0, 1, 1);
        issue(3'b111, 8'd0, 1'b1, 8'd0, 1, 1);
        drain();
        chk("full_tos", int'(tos), 255);
        issue(3'b001, 8'd0, 1'b0, 8'd254, 2, 1);
        drain();
        chk("full_pop_tos", int'(tos), 254);

        // PUSHI/DUP/AND/NOT chain
        stack_ctl(1);
        issue(3'b000, 8'h0F, 1'b0, 8'h0F, 2, 1);
        issue(3'b111, 8'd0, 1'b0, 8'h0F, 2, 1);
        issue(3'b100, 8'd0, 1'b0, 8'h0F, 4, 1);
        issue(3'b110, 8'd0, 1'b0, 8'hF0, 3, 1);
        drain();
        chk("chain_tos", int'(tos), 1);
        chk("chain_top", int'(stk_dout), 8'hF0);
        issue(3'b000, 8'h3C, 1'b0, 8'h3C, 2, 1);
        issue(3'b101, 8'd0, 1'b0, 8'hFC, 4, 1);
        drain();

        // reset while the ADD sits in POP_B
        stack_ctl(1);
        issue(3'b000, 8'd1, 1'b0, 8'd1, 2, 1);
        issue(3'b000, 8'd2, 1'b0, 8'd2, 2, 1);
        drain();
        issue(3'b010, 8'd0, 1'b0, 8'd3, 4, 0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes", int'({stk_push, stk_pop, res_valid, err}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_data", int'(res_data), 0);
        chk("abort_din", int'(stk_din), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("abort_tos", int'(tos), 0);
        rst = 1'b1;
        issue(3'b000, 8'd9, 1'b0, 8'd9, 2, 1);
        drain();
        chk("post_abort_tos", int'(tos), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 SHALL have these ports:
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode (see REQ-006).
- cmd_imm  in  8  immediate for PUSHI.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  8  result of the completed command.
- err  out  1  one-cycle pulse: command rejected, stack untouched.
- busy  out  1  high in every state except IDLE.
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_din  out  8  data to push.
- stk_dout  in  8  stack top data, combinational from the stack (0 when empty).
- stk_tos  in  8  stack depth (entries held, 0..255).

REQ-002 SHALL have one clock (clk) and a synchronous, active-low reset (rst); there SHALL be no asynchronous logic.

Function
REQ-003 SHALL act as the driving (master) end of the push/pop stack interface. Stack commits push and pop on posedge.
REQ-004 SHALL never assert stk_push and stk_pop in the same cycle, and SHALL assert each for exactly one cycle per access.
REQ-005 States: IDLE, POP_A, POP_B, PUSH_R, DONE, ERR. cmd_ready = (state==IDLE && rst==1). A command is accepted on a posedge with cmd_valid && cmd_ready.
REQ-006 cmd_op and cmd_imm SHALL be captured at acceptance; later input changes SHALL be ignored. Opcodes (a = top, b = entry below top):
- 000 PUSHI: push imm.
- 001 POP: pop a; result = a.
- 010 ADD: push (b+a) mod 256.
- 011 SUB: push (b-a) mod 256.
- 100 AND: push b&a.
- 101 OR: push b|a.
- 110 NOT: push ~a.
- 111 DUP: push a.
REQ-007 Depth check at acceptance, using stk_tos:
- PUSHI requires tos<255.
- POP and NOT require tos>=1.
- Binary ops (ADD, SUB, AND, OR) require tos>=2.
- DUP requires 1<=tos<=254.
- On violation: next state is ERR.
REQ-008 POP_A SHALL latch a=stk_dout and assert stk_pop. POP_B SHALL latch b=stk_dout (the post-pop top) and assert stk_pop.
REQ-009 PUSH_R SHALL drive stk_din = result and assert stk_push. For DUP, stk_din = stk_dout and no pop occurs.
REQ-010 State sequences after acceptance (cycle T = accept edge):
- Binary ops: POP_A, POP_B, PUSH_R, DONE (res_valid in cycle T+4).
- NOT: POP_A, PUSH_R, DONE (T+3).
- POP: POP_A, DONE (T+2).
- PUSHI and DUP: PUSH_R, DONE (T+2).
- Rejected: ERR (T+1).
REQ-011 DONE SHALL assert res_valid=1 for one cycle with res_data = result (for PUSHI, res_data = imm). The next state is IDLE.
REQ-012 res_data SHALL hold its last value until the next DONE.
REQ-013 ERR SHALL assert err=1 for one cycle, with res_valid=0 and no stack strobes. The next state is IDLE.
REQ-014 Throughput: a new command SHALL be accepted no earlier than the edge after DONE/ERR (no overlap).
REQ-015 Arithmetic is 8-bit unsigned and wraps; no carry or borrow output.
REQ-016 stk_din SHALL be 0 whenever stk_push=0.

Reset
REQ-017 On a posedge with rst==0:
- state goes to IDLE.
- res_valid, err, stk_push, stk_pop, busy, res_data, stk_din and the internal a/b/op registers go to 0.
- cmd_ready SHALL be 0 while rst==0.
REQ-018 Reset mid-command SHALL abort the command. No stack strobe occurs from the cycle following the reset edge, and already-popped operands are discarded (not restored).

Verification
REQ-019 Stack empty; PUSHI 5, then PUSHI 3, then SUB -> stk_tos ends at 1, res_data=2, res_valid exactly 4 cycles after the SUB accept edge.
REQ-020 PUSHI 200, then PUSHI 100, then ADD -> res_data=44 (wrap), stack top=44, tos=1.
REQ-021 Stack empty; ADD issued -> err pulses 1 cycle at T+1, no push/pop, tos stays 0, cmd_ready back to 1 at T+2.
REQ-022 Stack holding 255 entries; PUSHI 7 -> err, tos stays 255. Then POP -> res_data = old top, tos=254.
REQ-023 PUSHI 0x0F, DUP, AND, NOT -> results 0x0F, 0x0F, 0x0F, 0xF0; tos=1; push and pop never both high in any cycle.
REQ-024 rst driven low during POP_B of an ADD -> next cycle no strobes, all outputs 0, state IDLE; after release, PUSHI 9 completes normally with res_data=9.
